// File: rtl/destuff_pkg.sv
// Shared types and constants for the bit-destuffing receiver.
package destuff_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam int RUN_LEN_DEF = 5;
   localparam int BAUD_MIN    = 2;

   // Baud values below the minimum cannot produce a distinct mid-bit sample point.
   function automatic int unsigned eff_period(input int unsigned baud);
      return (baud < BAUD_MIN) ? BAUD_MIN : baud;
   endfunction

endpackage

// File: rtl/baud_sampler.sv
// Latches the line-bit period at frame start and emits a mid-bit sample tick.
module baud_sampler
   import destuff_pkg::*;
#(
   parameter int BAUD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              enable,
   input  logic [BAUD_W-1:0] baudrate,
   output logic              sample_tick
);

   logic [BAUD_W-1:0] period_q, period_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d;

   // The start cycle is line-bit cycle 0, so the counter resumes at 1.
   always_comb begin
      period_d = period_q;
      cnt_d    = '0;
      if (start) begin
         period_d = BAUD_W'(eff_period(32'(baudrate)));
         cnt_d    = BAUD_W'(1);
      end else if (enable) begin
         cnt_d = (cnt_q == period_q - BAUD_W'(1)) ? '0 : cnt_q + BAUD_W'(1);
      end
   end

   assign sample_tick = enable && (cnt_q == (period_q >> 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= BAUD_W'(BAUD_MIN);
         cnt_q    <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/destuffer_rx.sv
// Receive-side destuffer: drops stuff bits, packs data bits MSB-first into words.
module destuffer_rx
   import destuff_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int RUN_LEN = RUN_LEN_DEF,
   parameter int BAUD_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxi,
   input  logic              rxin,
   input  logic [BAUD_W-1:0] baudrate,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              frame_active,
   output logic              stuff_err,
   output logic              overrun,
   output logic              frag_err
);

   localparam int RUN_W  = $clog2(RUN_LEN + 1);
   localparam int BCNT_W = $clog2(DATA_W + 1);

   state_t              state_q, state_d;
   logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
   logic                last_q, last_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                frame_active_q, frame_active_d;
   logic                stuff_err_q, stuff_err_d;
   logic                overrun_q, overrun_d;
   logic                frag_err_q, frag_err_d;

   logic start;
   logic enable;
   logic sample_tick;

   assign start  = (state_q == IDLE) && !rxi;
   assign enable = (state_q == RUN) && !rxi;

   baud_sampler #(
      .BAUD_W(BAUD_W)
   ) u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .enable     (enable),
      .baudrate   (baudrate),
      .sample_tick(sample_tick)
   );

   always_comb begin
      state_d      = state_q;
      run_cnt_d    = run_cnt_q;
      last_d       = last_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q && !data_ready;
      stuff_err_d  = 1'b0;
      overrun_d    = 1'b0;
      frag_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rxi) begin
               state_d   = RUN;
               run_cnt_d = '0;
               bit_cnt_d = '0;
               last_d    = 1'b0;
               shreg_d   = '0;
            end
         end
         RUN: begin
            if (rxi) begin
               state_d    = IDLE;
               frag_err_d = (bit_cnt_q != '0);
               bit_cnt_d  = '0;
            end else if (sample_tick) begin
               if (run_cnt_q == RUN_W'(RUN_LEN)) begin
                  // Stuff position: bit is dropped whether or not it is a legal inversion.
                  stuff_err_d = (rxin == last_q);
                  run_cnt_d   = RUN_W'(1);
                  last_d      = rxin;
               end else begin
                  run_cnt_d = (rxin == last_q && run_cnt_q != '0) ? run_cnt_q + RUN_W'(1)
                                                                 : RUN_W'(1);
                  last_d    = rxin;
                  shreg_d   = {shreg_q[DATA_W-2:0], rxin};
                  if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
                     data_out_d   = shreg_d;
                     overrun_d    = data_valid_q && !data_ready;
                     data_valid_d = 1'b1;
                     bit_cnt_d    = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      frame_active_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         run_cnt_q      <= '0;
         last_q         <= 1'b0;
         shreg_q        <= '0;
         bit_cnt_q      <= '0;
         data_out_q     <= '0;
         data_valid_q   <= 1'b0;
         frame_active_q <= 1'b0;
         stuff_err_q    <= 1'b0;
         overrun_q      <= 1'b0;
         frag_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         run_cnt_q      <= run_cnt_d;
         last_q         <= last_d;
         shreg_q        <= shreg_d;
         bit_cnt_q      <= bit_cnt_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         frame_active_q <= frame_active_d;
         stuff_err_q    <= stuff_err_d;
         overrun_q      <= overrun_d;
         frag_err_q     <= frag_err_d;
      end
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign frame_active = frame_active_q;
   assign stuff_err    = stuff_err_q;
   assign overrun      = overrun_q;
   assign frag_err     = frag_err_q;

endmodule

// File: tb/tb_destuffer_rx.sv
// Scoreboard bench for destuffer_rx: encodes frames, queues expected words, checks on accept.
module tb_destuffer_rx;

   localparam int DATA_W  = 8;
   localparam int RUN_LEN = 5;
   localparam int BAUD_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rxi = 1'b1;
   logic              rxin = 1'b1;
   logic [BAUD_W-1:0] baudrate = 8'd4;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready = 1'b1;
   logic              frame_active;
   logic              stuff_err;
   logic              overrun;
   logic              frag_err;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] tx_bytes[$];
   bit                line_q[$];

   int stuff_cnt = 0;
   int overrun_cnt = 0;
   int frag_cnt = 0;
   int valid_cycles = 0;

   always #5 clk = ~clk;

   destuffer_rx #(
      .DATA_W (DATA_W),
      .RUN_LEN(RUN_LEN),
      .BAUD_W (BAUD_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rxi         (rxi),
      .rxin        (rxin),
      .baudrate    (baudrate),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_active(frame_active),
      .stuff_err   (stuff_err),
      .overrun     (overrun),
      .frag_err    (frag_err)
   );

   // Output monitor: pops the scoreboard on every accepted word and tallies pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stuff_err)  stuff_cnt++;
         if (overrun)    overrun_cnt++;
         if (frag_err)   frag_cnt++;
         if (data_valid) valid_cycles++;
         if (data_valid && data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got %02h, required none", data_out);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_q.pop_front();
               if (data_out !== e) begin
                  errors++;
                  $display("FAIL word: got %02h, required %02h", data_out, e);
               end
            end
         end
      end
   end

   task automatic clear_counts();
      stuff_cnt = 0;
      overrun_cnt = 0;
      frag_cnt = 0;
      valid_cycles = 0;
   endtask

   // Independent stuffer model: after RUN_LEN equal bits insert the inverse.
   task automatic encode();
      int run = 0;
      bit last = 1'b0;
      line_q.delete();
      foreach (tx_bytes[i]) begin
         for (int k = DATA_W - 1; k >= 0; k--) begin
            bit b;
            b = tx_bytes[i][k];
            line_q.push_back(b);
            if (run > 0 && b == last) run++;
            else run = 1;
            last = b;
            if (run == RUN_LEN) begin
               line_q.push_back(!last);
               last = !last;
               run = 1;
            end
         end
      end
   endtask

   task automatic send_line(input int p);
      @(posedge clk); #1;
      rxi = 1'b0;
      foreach (line_q[i]) begin
         rxin = line_q[i];
         repeat (p) @(posedge clk);
         #1;
      end
      rxi = 1'b1;
      rxin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_count(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({data_out, data_valid, frame_active, stuff_err, overrun, frag_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %02h/%b%b%b%b%b, required 0",
                  data_out, data_valid, frame_active, stuff_err, overrun, frag_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      clear_counts();
      baudrate = 8'd4;
      data_ready = 1'b1;
      tx_bytes = '{8'hA5, 8'h3C};
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      encode();
      check_count("basic_no_stuffing_len", line_q.size(), 16);
      send_line(4);
      wait_drain("basic");
      check_count("basic_valid_cycles", valid_cycles, 2);
      check_count("basic_errs", stuff_cnt + overrun_cnt + frag_cnt, 0);
   endtask

   task automatic test_stuffing();
      clear_counts();
      baudrate = 8'd4;
      tx_bytes = '{8'h01, 8'hF8};
      exp_q.push_back(8'h01);
      exp_q.push_back(8'hF8);
      encode();
      check_count("stuff_line_len", line_q.size(), 18);
      send_line(4);
      wait_drain("stuffing");
      check_count("stuffing_stuff_err", stuff_cnt, 0);
      check_count("stuffing_frag", frag_cnt, 0);
   endtask

   task automatic test_stuff_err();
      clear_counts();
      baudrate = 8'd4;
      // Five ones, an illegal one at the stuff position, then 0,0,1.
      line_q = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
      exp_q.push_back(8'hF9);
      send_line(4);
      wait_drain("stuff_err");
      check_count("stuff_err_pulses", stuff_cnt, 1);
      check_count("stuff_err_frag", frag_cnt, 0);
   endtask

   task automatic test_overrun();
      clear_counts();
      baudrate = 8'd5;
      data_ready = 1'b0;
      tx_bytes = '{8'h12, 8'h34};
      exp_q.push_back(8'h34);
      encode();
      send_line(5);
      check_count("overrun_pulses", overrun_cnt, 1);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 8'h34) begin
         errors++;
         $display("FAIL overrun_hold: got valid=%b data=%02h, required valid=1 data=34",
                  data_valid, data_out);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (data_valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun_valid_stays: got %b, required 1", data_valid);
      end
      data_ready = 1'b1;
      wait_drain("overrun");
      @(posedge clk); #1;
      checks++;
      if (data_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_valid_drop: got %b, required 0", data_valid);
      end
   endtask

   task automatic test_fragment();
      clear_counts();
      baudrate = 8'd4;
      line_q = '{1, 0, 1};
      send_line(4);
      check_count("frag_pulses", frag_cnt, 1);
      check_count("frag_no_word", valid_cycles, 0);
      checks++;
      if (frame_active !== 1'b0) begin
         errors++;
         $display("FAIL frag_idle: got frame_active=%b, required 0", frame_active);
      end
      tx_bytes = '{8'hC3};
      exp_q.push_back(8'hC3);
      encode();
      send_line(4);
      wait_drain("frag_next");
      check_count("frag_next_pulses", frag_cnt, 1);
   endtask

   task automatic test_reset_mid_frame();
      clear_counts();
      baudrate = 8'd4;
      data_ready = 1'b0;
      tx_bytes = '{8'hAA};
      encode();
      send_line(4);
      baudrate = 8'd0;
      @(posedge clk); #1;
      rxi = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rxin = i[0];
         repeat (2) @(posedge clk);
         #1;
      end
      checks++;
      if (frame_active !== 1'b1 || data_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_state: got active=%b valid=%b, required 1/1",
                  frame_active, data_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({data_out, data_valid, frame_active, stuff_err, overrun, frag_err} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %02h/%b%b%b%b%b, required 0",
                  data_out, data_valid, frame_active, stuff_err, overrun, frag_err);
      end
      rxi = 1'b1;
      rxin = 1'b1;
      data_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tx_bytes = '{8'h55};
      exp_q.push_back(8'h55);
      encode();
      send_line(2);
      wait_drain("post_reset");
      check_count("post_reset_frag", frag_cnt, 0);
      check_count("post_reset_stuff", stuff_cnt, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuffing();
      test_stuff_err();
      test_overrun();
      test_fragment();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
